pac_move_ctrl: RTL

Sequences Pac-Man sprite movement for the VGA renderer.
- Merges keypad and PS2 direction commands into a pending direction.
- Once per frame, checks the maze wall map through a shared synchronous map ROM port, then commits the new sprite top-left position (pac_x, pac_y).
- Sits between the Keypad/PS2_keyboard blocks and the sprite address/colour logic; replaces ad-hoc x/y updates in the top level.

---
 rtl/pac_move_if.sv | 24 ++
 rtl/pac_move_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pac_move_if.sv
// pac_move_if: command inputs, map ROM port and sprite state of the Pac-Man move controller.
interface pac_move_if;
  logic        frame_tick;
  logic [4:0]  key_code;
  logic        key_ready;
  logic [7:0]  ps2_code;
  logic        ps2_ready;
  logic [10:0] map_addr;
  logic        map_rd;
  logic        map_wall;
  logic [9:0]  pac_x;
  logic [8:0]  pac_y;
  logic [2:0]  dir;
  logic        moving;
  logic        busy;
  modport master (
    input  frame_tick, key_code, key_ready, ps2_code, ps2_ready, map_wall,
    output map_addr, map_rd, pac_x, pac_y, dir, moving, busy
  );
  modport slave (
    output frame_tick, key_code, key_ready, ps2_code, ps2_ready, map_wall,
    input  map_addr, map_rd, pac_x, pac_y, dir, moving, busy
  );
endinterface

// File: rtl/pac_move_ctrl.sv
// pac_move_ctrl: per-frame Pac-Man movement with buffered turns, wall checks and tunnel wrap.
module pac_move_ctrl #(
  parameter int STEP   = 2,
  parameter int X_INIT = 30,
  parameter int Y_INIT = 146,
  parameter int X_MAX  = 608,
  parameter int Y_MAX  = 448
) (
  input logic         clk,
  input logic         rst,
  pac_move_if.master  io
);
  typedef enum logic [1:0] {IDLE, CHK_A, CHK_B, DECIDE} state_t;
  localparam logic [9:0] STP = 10'(STEP);
  localparam logic [9:0] XM  = 10'(X_MAX);
  localparam logic [9:0] YM  = 10'(Y_MAX);
  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [2:0]  dir_q, dir_d, next_dir_q, next_dir_d, cand_q, cand_d;
  logic        from_next_q, from_next_d, moving_q, moving_d, wall_a_q, wall_a_d;
  logic        tick_q, tick_d, kr_q, pr_q;
  logic [2:0]  key_dir, ps2_dir, cmd, pick;
  logic [9:0]  y10, nx, ny, ax, ay, bx, by;
  logic        wrap, oob, skip, wall_now;
  function automatic logic [10:0] tile_addr(input logic [9:0] cx, input logic [9:0] cy);
    tile_addr = (({1'b0, cy} >> 4) << 5) + (({1'b0, cy} >> 4) << 3) + ({1'b0, cx} >> 4);
  endfunction
  always_comb begin
    key_dir = io.key_code == 5'h0c ? 3'd1 : io.key_code == 5'h0e ? 3'd2 :
              io.key_code == 5'h09 ? 3'd3 : io.key_code == 5'h11 ? 3'd4 : 3'd0;
    ps2_dir = io.ps2_code == 8'h6b ? 3'd1 : io.ps2_code == 8'h74 ? 3'd2 :
              io.ps2_code == 8'h75 ? 3'd3 : io.ps2_code == 8'h72 ? 3'd4 : 3'd0;
    cmd = (io.key_ready && !kr_q && key_dir != 3'd0) ? key_dir :
          (io.ps2_ready && !pr_q) ? ps2_dir : 3'd0;
  end
  // Candidate position and the two leading-edge corners for the attempted direction
  always_comb begin
    y10  = {1'b0, y_q};
    wrap = (cand_q == 3'd1 && x_q < STP) || (cand_q == 3'd2 && x_q + STP > XM);
    oob  = (cand_q == 3'd3 && y10 < STP) || (cand_q == 3'd4 && y10 + STP > YM);
    skip = wrap || oob;
    nx   = cand_q == 3'd1 ? (wrap ? XM : x_q - STP) :
           cand_q == 3'd2 ? (wrap ? 10'd0 : x_q + STP) : x_q;
    ny   = cand_q == 3'd3 ? y10 - STP : cand_q == 3'd4 ? y10 + STP : y10;
    ax   = cand_q == 3'd2 ? nx + 10'd31 : nx;
    bx   = cand_q != 3'd1 ? nx + 10'd31 : nx;
    ay   = cand_q == 3'd4 ? ny + 10'd31 : ny;
    by   = cand_q != 3'd3 ? ny + 10'd31 : ny;
    wall_now = skip ? oob : io.map_wall;
  end
  assign io.map_rd   = (state_q == CHK_A || state_q == CHK_B) && !skip;
  assign io.map_addr = state_q == CHK_A ? tile_addr(ax, ay) :
                       state_q == CHK_B ? tile_addr(bx, by) : 11'd0;
  assign io.pac_x    = x_q;
  assign io.pac_y    = y_q;
  assign io.dir      = dir_q;
  assign io.moving   = moving_q;
  assign io.busy     = state_q != IDLE;
  assign tick_d      = io.frame_tick && state_q == IDLE;
  assign pick        = next_dir_q != 3'd0 ? next_dir_q : dir_q;
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    next_dir_d  = next_dir_q;
    cand_d      = cand_q;
    from_next_d = from_next_q;
    moving_d    = moving_q;
    wall_a_d    = wall_a_q;
    case (state_q)
      IDLE: if (tick_q) begin
        moving_d    = 1'b0;
        cand_d      = pick;
        from_next_d = next_dir_q != 3'd0;
        state_d     = pick != 3'd0 ? CHK_A : IDLE;
      end
      CHK_A: state_d = CHK_B;
      CHK_B: begin
        wall_a_d = wall_now;
        state_d  = DECIDE;
      end
      DECIDE: if (!wall_a_q && !wall_now) begin
        x_d        = nx;
        y_d        = ny[8:0];
        dir_d      = cand_q;
        moving_d   = 1'b1;
        next_dir_d = from_next_q ? 3'd0 : next_dir_q;
        state_d    = IDLE;
      end else if (from_next_q && dir_q != 3'd0) begin
        cand_d      = dir_q;
        from_next_d = 1'b0;
        state_d     = CHK_A;
      end else begin
        moving_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
    if (cmd != 3'd0) next_dir_d = cmd;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      x_q         <= 10'(X_INIT);
      y_q         <= 9'(Y_INIT);
      dir_q       <= 3'd0;
      next_dir_q  <= 3'd0;
      cand_q      <= 3'd0;
      from_next_q <= 1'b0;
      moving_q    <= 1'b0;
      wall_a_q    <= 1'b0;
      tick_q      <= 1'b0;
      kr_q        <= 1'b0;
      pr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      next_dir_q  <= next_dir_d;
      cand_q      <= cand_d;
      from_next_q <= from_next_d;
      moving_q    <= moving_d;
      wall_a_q    <= wall_a_d;
      tick_q      <= tick_d;
      kr_q        <= io.key_ready;
      pr_q        <= io.ps2_ready;
    end
  end
endmodule
